// File: rtl/alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu: registered 8-bit ALU (FORWARD/ADD/AND/OR; SUB/XOR/SLL/SRL when the    |
// | macro ALU_EXT_OPS_EN is defined).                          Revision: 1.0   |
// +----------------------------------------------------------------------------+
module alu #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] DATA1,
    input  logic [DATA_WIDTH-1:0] DATA2,
    input  logic [2:0]            SELECT,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  ZERO,
    output logic                  CARRY
);

    localparam logic [2:0] c_OP_FWD = 3'b000;
    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
`ifdef ALU_EXT_OPS_EN
    localparam logic [2:0] c_OP_SUB = 3'b100;
    localparam logic [2:0] c_OP_XOR = 3'b101;
    localparam logic [2:0] c_OP_SLL = 3'b110;
    localparam logic [2:0] c_OP_SRL = 3'b111;
`endif

    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_carry;

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_carry;

`ifdef ALU_EXT_OPS_EN
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH:0]   w_shl;
    logic [DATA_WIDTH:0]   w_shr;
    logic [2:0]            w_shamt;
`endif

    assign w_sum = {1'b0, DATA1} + {1'b0, DATA2};

`ifdef ALU_EXT_OPS_EN
    assign w_diff  = {1'b0, DATA1} - {1'b0, DATA2};
    assign w_shamt = DATA2[2:0];
    // One guard bit on each side captures the last bit shifted out (0 for a zero shift).
    assign w_shl   = {1'b0, DATA1} << w_shamt;
    assign w_shr   = {DATA1, 1'b0} >> w_shamt;
`endif

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (SELECT)
            c_OP_FWD: w_result = DATA2;
            c_OP_ADD: begin
                w_result = w_sum[DATA_WIDTH-1:0];
                w_carry  = w_sum[DATA_WIDTH];
            end
            c_OP_AND: w_result = DATA1 & DATA2;
            c_OP_OR:  w_result = DATA1 | DATA2;
`ifdef ALU_EXT_OPS_EN
            c_OP_SUB: begin
                w_result = w_diff[DATA_WIDTH-1:0];
                w_carry  = ~w_diff[DATA_WIDTH];
            end
            c_OP_XOR: w_result = DATA1 ^ DATA2;
            c_OP_SLL: begin
                w_result = w_shl[DATA_WIDTH-1:0];
                w_carry  = w_shl[DATA_WIDTH];
            end
            c_OP_SRL: begin
                w_result = w_shr[DATA_WIDTH:1];
                w_carry  = w_shr[0];
            end
`endif
            default: begin
                w_result = '0;
                w_carry  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_carry  <= 1'b0;
        end else begin
            r_result <= w_result;
            r_zero   <= ~|w_result;
            r_carry  <= w_carry;
        end
    end

    assign RESULT = r_result;
    assign ZERO   = r_zero;
    assign CARRY  = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// Testbench for alu: directed vector table, reset/latency sequences and
// randomized operations checked against an arithmetic reference model.
module tb_alu;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [2:0] SELECT;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       CARRY;

    int checks;
    int failures;

    alu #(.DATA_WIDTH(8)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .SELECT (SELECT),
        .RESULT (RESULT),
        .ZERO   (ZERO),
        .CARRY  (CARRY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d1;
        logic [7:0] d2;
        logic [2:0] sel;
        logic [7:0] res;
        logic       z;
        logic       c;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%02h required=0x%02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] r, input logic z, input logic c);
        check({name, ".RESULT"}, RESULT, r);
        check({name, ".ZERO"}, {7'd0, ZERO}, {7'd0, z});
        check({name, ".CARRY"}, {7'd0, CARRY}, {7'd0, c});
    endtask

    // Reference model: plain integer arithmetic straight from the operation definitions.
    task automatic model(input int a, input int b, input int sel,
                         output logic [7:0] r, output logic z, output logic c);
        int res;
        int cy;
        int s;
        res = 0;
        cy  = 0;
        s   = b % 8;
        case (sel)
            0: res = b;
            1: begin res = (a + b) % 256; cy = (a + b) / 256; end
            2: res = a & b;
            3: res = a | b;
`ifdef ALU_EXT_OPS_EN
            4: begin res = (a - b + 256) % 256; cy = (a >= b) ? 1 : 0; end
            5: res = a ^ b;
            6: begin res = (a * (1 << s)) % 256; cy = (s == 0) ? 0 : (a / (1 << (8 - s))) % 2; end
            7: begin res = a / (1 << s); cy = (s == 0) ? 0 : (a / (1 << (s - 1))) % 2; end
`endif
            default: begin res = 0; cy = 0; end
        endcase
        r = res[7:0];
        z = (res == 0);
        c = cy[0];
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        @(negedge CLK);
        DATA1  = a;
        DATA2  = b;
        SELECT = s;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] er;
        logic       ez;
        logic       ec;
        checks   = 0;
        failures = 0;
        DATA1    = 8'h00;
        DATA2    = 8'h00;
        SELECT   = 3'b000;
        RESET_N  = 1'b1;

        // Asynchronous reset before any clock edge
        #2 RESET_N = 1'b0;
        #1 check_all("reset_async", 8'h00, 1'b1, 1'b0);
        @(negedge CLK);
        RESET_N = 1'b1;

        vecs.push_back('{8'h0F, 8'hF1, 3'b000, 8'hF1, 1'b0, 1'b0});
        vecs.push_back('{8'h0F, 8'hF1, 3'b001, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h0F, 8'h01, 3'b001, 8'h10, 1'b0, 1'b0});
        vecs.push_back('{8'h0F, 8'hF1, 3'b010, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h0F, 8'hF1, 3'b011, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h00, 3'b000, 8'h00, 1'b1, 1'b0});
`ifdef ALU_EXT_OPS_EN
        vecs.push_back('{8'h05, 8'h07, 3'b100, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 8'h07, 3'b100, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h0F, 8'hF1, 3'b101, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h81, 8'h01, 3'b110, 8'h02, 1'b0, 1'b1});
        vecs.push_back('{8'h81, 8'h00, 3'b110, 8'h81, 1'b0, 1'b0});
        vecs.push_back('{8'h81, 8'h01, 3'b111, 8'h40, 1'b0, 1'b1});
        vecs.push_back('{8'h81, 8'h08, 3'b111, 8'h81, 1'b0, 1'b0});
`else
        vecs.push_back('{8'h05, 8'h07, 3'b100, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 3'b110, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 3'b111, 8'h00, 1'b1, 1'b0});
`endif
        foreach (vecs[i]) begin
            drive(vecs[i].d1, vecs[i].d2, vecs[i].sel);
            check_all($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].c);
        end

        // Latency: changing SELECT between edges must not disturb the outputs
        drive(8'h0F, 8'hF1, 3'b000);
        @(negedge CLK);
        SELECT = 3'b010;
        #1 check_all("latency_hold", 8'hF1, 1'b0, 1'b0);
        @(posedge CLK);
        #1 check_all("latency_update", 8'h01, 1'b0, 1'b0);
        @(posedge CLK);
        #1 check_all("latency_stable", 8'h01, 1'b0, 1'b0);

        // Mid-cycle reset discards the pending result; first edge after release loads normally
        @(negedge CLK);
        SELECT = 3'b011;
        #1 RESET_N = 1'b0;
        #1 check_all("reset_mid", 8'h00, 1'b1, 1'b0);
        @(posedge CLK);
        #1 check_all("reset_held", 8'h00, 1'b1, 1'b0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1 check_all("reset_release", 8'hFF, 1'b0, 1'b0);

        for (int k = 0; k < 300; k++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic [2:0] s;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            s = 3'($urandom_range(0, 7));
            drive(a, b, s);
            model(int'(a), int'(b), int'(s), er, ez, ec);
            check_all($sformatf("rand%0d_sel%0d_%02h_%02h", k, s, a, b), er, ez, ec);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The parameter list SHALL be exactly one parameter:
  DATA_WIDTH, 8, operand/result width in bits; all width rules below use the default of 8.
REQ-002 The ports SHALL be, one per line:
  CLK  input  1  system clock; all state updates on the rising edge.
  RESET_N  input  1  reset; asynchronous, active-low.
  DATA1  input  8  first operand.
  DATA2  input  8  second operand.
  SELECT  input  3  operation code.
  RESULT  output  8  registered operation result.
  ZERO  output  1  registered flag; 1 when RESULT is 0x00.
  CARRY  output  1  registered carry/no-borrow flag.
REQ-003 The design SHALL have one clock; reset SHALL be asynchronous and active-low (CLK, RESET_N).

Function
REQ-004 RESULT, ZERO and CARRY SHALL be registered with one-cycle latency: operands and SELECT sampled at rising edge N appear on the outputs after edge N.
REQ-005 With SELECT=000 (FORWARD), RESULT SHALL be DATA2 and CARRY SHALL be 0.
REQ-006 With SELECT=001 (ADD), RESULT SHALL be (DATA1+DATA2) mod 256 and CARRY SHALL be bit 8 of the 9-bit sum.
REQ-007 With SELECT=010 (AND), RESULT SHALL be DATA1 bitwise-AND DATA2 and CARRY SHALL be 0.
REQ-008 With SELECT=011 (OR), RESULT SHALL be DATA1 bitwise-OR DATA2 and CARRY SHALL be 0.
REQ-009 Codes 100-111 SHALL behave per REQ-014/REQ-015.
REQ-010 ZERO SHALL equal the NOR of the registered RESULT bits, updated in the same cycle as RESULT.
REQ-011 The outputs SHALL hold their last value while the inputs are stable; there is no enable and no handshake.
REQ-012 X/Z-free inputs SHALL never produce X on any output after reset.

Reset
REQ-013 While RESET_N=0, the outputs SHALL be RESULT=0x00, ZERO=1 and CARRY=0, applied immediately without waiting for CLK. Reset asserted mid-operation SHALL discard the pending result. The first rising edge with RESET_N=1 SHALL load normally.

Configuration
REQ-014 With the macro ALU_EXT_OPS_EN defined, the following SHALL be compiled in:
  100 SUB: RESULT=(DATA1-DATA2) mod 256; CARRY=1 when DATA1>=DATA2 (no borrow).
  101 XOR: RESULT=DATA1^DATA2; CARRY=0.
  110 SLL: RESULT=DATA1<<DATA2[2:0], zero-fill; CARRY=last bit shifted out (0 when the shift amount is 0).
  111 SRL: RESULT=DATA1>>DATA2[2:0], zero-fill; CARRY=last bit shifted out (0 when the shift amount is 0).
REQ-015 Without ALU_EXT_OPS_EN, codes 100-111 SHALL load RESULT=0x00 and CARRY=0, so ZERO=1.

Verification
REQ-016 Reset: RESET_N=0 asynchronously mid-cycle -> RESULT=0x00, ZERO=1, CARRY=0 before the next edge.
REQ-017 DATA1=0x0F, DATA2=0xF1, SELECT=000 -> after one edge RESULT=0xF1, ZERO=0, CARRY=0.
REQ-018 Same operands, SELECT=001 -> RESULT=0x00, ZERO=1, CARRY=1 (wrap-around); with 0x0F+0x01 -> RESULT=0x10, CARRY=0.
REQ-019 Same operands, SELECT=010 -> RESULT=0x01; SELECT=011 -> RESULT=0xFF; CARRY=0 in both cases.
REQ-020 SELECT=100 with 0x05,0x07: with ALU_EXT_OPS_EN -> RESULT=0xFE, CARRY=0; without it -> RESULT=0x00, ZERO=1.
REQ-021 Latency: change SELECT between edges -> outputs unchanged until the next rising edge, then updated exactly once.
